cpu_mem_responder: RTL
======================

Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU's MAR/MBR interface. The CPU is the initiator; it presents an address from MAR and, on writes, data from MBR.
- The block holds a 16 x 8 word store, inserts programmable wait states, and returns read data for the CPU to load into MBR.
- A side-band loader port preloads program words, which replaces driving instructions straight into the CPU.

Parameters:
- ADDR_W, 4, address width; matches MAR.
- DATA_W, 8, word width; matches MBR/IR.
- WAIT_CYCLES, 1, wait cycles inserted between request capture and ack; legal range 0..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  CPU access request; level, held until ack.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address (from MAR).
- wdata  in  DATA_W  write data (from MBR).
- rdata  out  DATA_W  read data; valid in the ack cycle, held until the next read ack.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high from request capture through the ack cycle.
- load_en  in  1  loader write strobe; one word per cycle.
- load_addr  in  ADDR_W  loader address.
- load_data  in  DATA_W  loader data.

Behaviour:
- Clock/reset: single clock `clk`; `reset` is synchronous and active-high. Reset cycle result: all 16 words = 0, rdata = 0, ack = 0, busy = 0, FSM = IDLE, wait counter = 0. Reset overrides everything, including an access in flight; no ack is ever produced for an aborted access.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req=1 captures addr, we and wdata into internal registers; busy goes high the next cycle. Go to WAIT if WAIT_CYCLES > 0, else RESP.
  - WAIT: the counter counts from 0 to WAIT_CYCLES-1, then the FSM goes to RESP.
  - RESP: perform the access using the captured registers.
    - Read: rdata <= mem[addr_q].
    - Write: mem[addr_q] <= wdata_q.
    - ack = 1 for exactly this cycle; busy stays 1. Next state is IDLE.
- Latency: ack arrives WAIT_CYCLES + 1 cycles after the req-capture edge.
- Back-to-back: IDLE must see req=1 again to start a new access. The earliest new capture is the cycle after the ack cycle. If req is still high then, it is treated as a new request; the CPU drops req when it sees ack.
- Changes to addr/we/wdata after capture are ignored.
- Loader:
  - load_en=1 writes mem[load_addr] <= load_data, in any state.
  - If it collides in the same cycle with a CPU write to the same address in RESP, the CPU write wins.
  - A loader write and a CPU read of the same address in the same RESP cycle: rdata returns the old value.
- Address wrap: none needed; addr is exactly ADDR_W bits. The depth is 2**ADDR_W.
- rdata is not changed by writes.

Optional Feature:
- Macro: MEM_WR_PROTECT_EN.
- With the macro defined:
  - Extra parameter PROTECT_TOP, default 7.
  - Extra output err (1 bit), reset 0.
  - A CPU write with addr_q <= PROTECT_TOP is suppressed; ack still pulses, and err = 1 in the ack cycle only.
  - The loader is never protected.
- Without the macro: no err port; all CPU writes are performed.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W and DATA_W constants.
  - mem_state_t enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Default WAIT_CYCLES.
- Sub-module mem_array_16x8:
  - Synchronous write port A (CPU) with priority over write port B (loader).
  - One registered read port.
  - Synchronous clear on reset.
- The FSM and wait counter stay in cpu_mem_responder.

Test Plan:
- Reset: hold reset 2 cycles mid-WAIT of an access -> ack never pulses, busy=0, rdata=0, and a read of address 3 afterwards returns 8'h00.
- Load then read: loader writes 8'h01 to address 0 and 8'hA5 to address 3; CPU read of addr 3 with WAIT_CYCLES=1 -> ack exactly 2 cycles after capture, rdata=8'hA5, busy high for 2 cycles.
- Write/read-back: CPU write 8'h3C to addr 15, then read addr 15 -> rdata=8'h3C. Before that read, the prior rdata value is unchanged by the write.
- Collision: CPU write 8'h11 to addr 5 in RESP while load_en writes 8'h22 to addr 5 -> a later read gives 8'h11.
- Zero wait and back-to-back: WAIT_CYCLES=0 with req held high for 3 reads (addrs 0, 1, 2) -> ack every 2nd cycle, returning the three preloaded words in order.
- MEM_WR_PROTECT_EN: CPU write 8'hFF to addr 2 -> ack=1 and err=1 in the same cycle, and mem[2] keeps its preload. A write to addr 9 -> err=0 and the data is stored.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the CPU memory responder: bus widths,
//                the default wait-state count and the responder state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_ADDR_W      = 4;   // matches MAR
    localparam int c_DATA_W      = 8;   // matches MBR / IR
    localparam int c_WAIT_CYCLES = 1;   // default wait states per access

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_array_16x8.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array_16x8
//  Description : 2**ADDR_W x DATA_W word store with two synchronous write
//                ports and one registered read port. Port A has priority over
//                port B when both write the same word in the same cycle.
//                A read returns the contents before any same-cycle write.
//  Ports       : clk, rst        - clock, synchronous active-high clear
//                i_a_we/addr/wdata - write port A (CPU, high priority)
//                i_b_we/addr/wdata - write port B (loader)
//                i_rd_en/i_rd_addr - registered read request
//                o_rd_data         - read data register (cleared on reset)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array_16x8
    import cpu_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            // Port A is assigned last so it wins an address collision.
            if (i_b_we) begin
                r_mem[i_b_addr] <= i_b_wdata;
            end
            if (i_a_we) begin
                r_mem[i_a_addr] <= i_a_wdata;
            end
            if (i_rd_en) begin
                r_rd_data <= r_mem[i_rd_addr];
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_responder
//  Description : Memory-side responder for the CPU MAR/MBR interface. Captures
//                a request, inserts WAIT_CYCLES wait states, then completes
//                the access with a one-cycle ack. A side-band loader can
//                write words at any time.
//  Options     : MEM_WR_PROTECT_EN - adds PROTECT_TOP parameter and err output;
//                CPU writes to addresses <= PROTECT_TOP are dropped and flagged.
//  Ports       : clk, reset                    - clock, sync active-high reset
//                req, we, addr, wdata          - CPU access request
//                rdata, ack, busy              - CPU response
//                load_en, load_addr, load_data - program loader
//                err (optional)                - protected-write flag
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_responder
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W,
    parameter int DATA_W      = c_DATA_W,
    parameter int WAIT_CYCLES = c_WAIT_CYCLES
`ifdef MEM_WR_PROTECT_EN
    ,
    parameter int PROTECT_TOP = 7
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
`ifdef MEM_WR_PROTECT_EN
    ,
    output logic              err
`endif
);

    localparam logic [3:0] c_WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    mem_state_t        r_state;
    logic [3:0]        r_wait_cnt;
    logic [ADDR_W-1:0] r_addr_q;
    logic              r_we_q;
    logic [DATA_W-1:0] r_wdata_q;
    logic              r_ack;
    logic              r_busy;

    logic              w_go_resp;
    logic [ADDR_W-1:0] w_acc_addr;
    logic              w_acc_we;
    logic              w_rd_en;
    logic              w_cpu_wr;
    logic              w_protect_q;

    // The response registers (ack, rdata, err) are loaded on the edge that
    // enters RESP so they are valid during the RESP cycle itself. With zero
    // wait states that edge is also the capture edge, so the access fields
    // come straight from the bus while IDLE.
    assign w_go_resp  = ((r_state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                        ((r_state == WAIT) && (r_wait_cnt == c_WAIT_LAST));
    assign w_acc_addr = (r_state == IDLE) ? addr : r_addr_q;
    assign w_acc_we   = (r_state == IDLE) ? we   : r_we_q;
    assign w_rd_en    = w_go_resp && !w_acc_we;

`ifdef MEM_WR_PROTECT_EN
    localparam logic [ADDR_W-1:0] c_PROTECT_TOP = PROTECT_TOP[ADDR_W-1:0];

    logic r_err;

    assign w_protect_q = (r_addr_q <= c_PROTECT_TOP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_go_resp && w_acc_we && (w_acc_addr <= c_PROTECT_TOP);
        end
    end

    assign err = r_err;
`else
    assign w_protect_q = 1'b0;
`endif

    // The CPU write commits at the end of the RESP cycle, which is the same
    // edge a loader write issued during RESP lands on; port A priority in the
    // array makes the CPU win that collision.
    assign w_cpu_wr = (r_state == RESP) && r_we_q && !w_protect_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
            r_addr_q   <= '0;
            r_we_q     <= 1'b0;
            r_wdata_q  <= '0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ack <= w_go_resp;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_addr_q   <= addr;
                        r_we_q     <= we;
                        r_wdata_q  <= wdata;
                        r_busy     <= 1'b1;
                        r_wait_cnt <= 4'd0;
                        r_state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        r_wait_cnt <= 4'd0;
                        r_state    <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy     <= 1'b0;
                    r_wait_cnt <= 4'd0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    mem_array_16x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk       (clk),
        .rst       (reset),
        .i_a_we    (w_cpu_wr),
        .i_a_addr  (r_addr_q),
        .i_a_wdata (r_wdata_q),
        .i_b_we    (load_en),
        .i_b_addr  (load_addr),
        .i_b_wdata (load_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_acc_addr),
        .o_rd_data (rdata)
    );

    assign ack  = r_ack;
    assign busy = r_busy;

endmodule
`default_nettype wire
